// File: rtl/data_mem_responder.sv
// Word-wide data-memory target for MEM-stage loads/stores: one outstanding
// request, fixed access latency, one-cycle ack with optional error flag.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic        busy_o,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] ADDR_LIM = 32'(4 * DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               err_q, err_d;

    logic [31:0]        mem [DEPTH_WORDS];
    logic               access;
    logic               bad;
    logic               mem_we;
    logic [IDX_W-1:0]   idx;

    // Full 32-bit compare: high address bits never alias into the array.
    assign bad    = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIM);
    assign idx    = addr_q[2 +: IDX_W];
    assign access = (state_q == S_WAIT) && (cnt_q == '0);
    assign mem_we = access && we_q && !bad;

    assign ready_o = (state_q != S_WAIT);
    assign busy_o  = (state_q == S_WAIT);
    assign ack_o   = (state_q == S_RESP);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_RESP;
                    err_d   = bad;
                    if (!bad && !we_q) rdata_d = mem[idx];
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage keeps its contents across reset; a reset forces IDLE, so an
    // in-flight write can never reach this port.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[idx] <= wdata_q;
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=1 instance, a
// vector table plus hand-written back-to-back, reset and ignore sequences.
module tb_data_mem_responder;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst   [2];
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic        ready [2];
    logic        busy  [2];
    logic        ack   [2];
    logic [31:0] rdata [2];
    logic        err   [2];

    int   lat [2] = '{2, 1};
    int   n_tests = 0;
    int   n_fail  = 0;
    int   ack_cnt [2] = '{0, 0};
    exp_t q0 [$];
    exp_t q1 [$];
    vec_t tbl [14];

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .CNT_W(8)) u_l2 (
        .clk_i(clk), .rst_i(rst[0]), .req_i(req[0]), .we_i(we[0]),
        .addr_i(addr[0]), .wdata_i(wdata[0]), .ready_o(ready[0]),
        .busy_o(busy[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .CNT_W(8)) u_l1 (
        .clk_i(clk), .rst_i(rst[1]), .req_i(req[1]), .we_i(we[1]),
        .addr_i(addr[1]), .wdata_i(wdata[1]), .ready_o(ready[1]),
        .busy_o(busy[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic push_exp(input int d, input logic [31:0] rd, input logic e);
        exp_t x;
        x.rd  = rd;
        x.err = e;
        if (d == 0) q0.push_back(x);
        else        q1.push_back(x);
    endtask

    task automatic mon(input int d);
        exp_t x;
        if (ack[d]) begin
            ack_cnt[d]++;
            if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack dut%0d: got ack expected none", d);
            end else begin
                x = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("rdata dut%0d", d), rdata[d], x.rd);
                chk($sformatf("err dut%0d", d), 32'(err[d]), 32'(x.err));
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic set_req(input int d, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd);
        req[d]   = r;
        we[d]    = w;
        addr[d]  = a;
        wdata[d] = wd;
    endtask

    // Called at a negedge; returns at the negedge where ack is visible.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err);
        int t;
        int c;
        set_req(d, 1'b1, w, a, wd);
        t = 0;
        while (!ready[d] && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("accept_timeout", 32'(t), 32'(0));
        push_exp(d, exp_rd, exp_err);
        @(negedge clk);
        chk("busy_after_accept", 32'(busy[d]), 32'(1));
        chk("ready_in_wait", 32'(ready[d]), 32'(0));
        chk("err_in_wait", 32'(err[d]), 32'(0));
        set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
        c = 0;
        while (!ack[d] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk($sformatf("latency dut%0d", d), 32'(c), 32'(lat[d]));
    endtask

    task automatic chk_idle(input int d);
        chk("rst_ready", 32'(ready[d]), 32'(1));
        chk("rst_busy", 32'(busy[d]), 32'(0));
        chk("rst_ack", 32'(ack[d]), 32'(0));
        chk("rst_err", 32'(err[d]), 32'(0));
        chk("rst_rdata", rdata[d], 32'h0);
    endtask

    initial begin
        int c;
        tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 32'h00000000, 1'b0};
        tbl[1]  = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h0,        32'h11112222, 32'hDEADBEEF, 1'b0};
        tbl[3]  = '{1'b1, 32'h8,        32'hAAAA5555, 32'hDEADBEEF, 1'b0};
        tbl[4]  = '{1'b0, 32'h13,       32'h0,        32'hDEADBEEF, 1'b1};
        tbl[5]  = '{1'b1, 32'h400,      32'hCAFEBABE, 32'hDEADBEEF, 1'b1};
        tbl[6]  = '{1'b0, 32'h0,        32'h0,        32'h11112222, 1'b0};
        tbl[7]  = '{1'b1, 32'h3FC,      32'hA5A5A5A5, 32'h11112222, 1'b0};
        tbl[8]  = '{1'b0, 32'h3FC,      32'h0,        32'hA5A5A5A5, 1'b0};
        tbl[9]  = '{1'b0, 32'h400,      32'h0,        32'hA5A5A5A5, 1'b1};
        tbl[10] = '{1'b0, 32'h10000000, 32'h0,        32'hA5A5A5A5, 1'b1};
        tbl[11] = '{1'b1, 32'h2,        32'h0,        32'hA5A5A5A5, 1'b1};
        tbl[12] = '{1'b0, 32'h0,        32'h0,        32'h11112222, 1'b0};
        tbl[13] = '{1'b0, 32'h10,       32'h0,        32'hDEADBEEF, 1'b0};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b0;
            set_req(d, 1'b0, 1'b0, 32'h0, 32'h0);
        end

        // reset held, then released with no request
        repeat (3) @(negedge clk);
        chk_idle(0);
        chk_idle(1);
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        repeat (2) @(negedge clk);
        chk_idle(0);
        chk_idle(1);

        for (int i = 0; i < 14; i++)
            do_req(0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err);

        // back-to-back: req held through RESP, read follows write of 0x14
        set_req(0, 1'b1, 1'b1, 32'h14, 32'h5);
        push_exp(0, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        c = 0;
        while (!ack[0] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_first_latency", 32'(c), 32'(2));
        set_req(0, 1'b1, 1'b0, 32'h14, 32'h0);
        push_exp(0, 32'h5, 1'b0);
        @(negedge clk);
        chk("b2b_accept_on_ack", 32'(busy[0]), 32'(1));
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        c = 1;
        while (!ack[0] && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("b2b_ack_spacing", 32'(c), 32'(3));

        // reset during WAIT drops the write
        set_req(0, 1'b1, 1'b1, 32'h8, 32'h1234);
        @(negedge clk);
        chk("rstmid_busy", 32'(busy[0]), 32'(1));
        rst[0] = 1'b0;
        #1;
        chk("rstmid_ready_now", 32'(ready[0]), 32'(1));
        chk("rstmid_busy_now", 32'(busy[0]), 32'(0));
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        do_req(0, 1'b0, 32'h8, 32'h0, 32'hAAAA5555, 1'b0);

        // LATENCY=1: extra request held while busy is ignored
        do_req(1, 1'b1, 32'h20, 32'h77, 32'h0, 1'b0);
        set_req(1, 1'b1, 1'b0, 32'h20, 32'h0);
        push_exp(1, 32'h77, 1'b0);
        @(negedge clk);
        chk("l1_busy", 32'(busy[1]), 32'(1));
        set_req(1, 1'b1, 1'b1, 32'h20, 32'hFFFF);
        @(negedge clk);
        chk("l1_ack_next_cycle", 32'(ack[1]), 32'(1));
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        chk("l1_ack_count", 32'(ack_cnt[1]), 32'(2));
        do_req(1, 1'b0, 32'h20, 32'h0, 32'h77, 1'b0);
        do_req(1, 1'b0, 32'h401, 32'h0, 32'h77, 1'b1);

        repeat (3) @(negedge clk);
        chk("queue0_drained", 32'(q0.size()), 32'(0));
        chk("queue1_drained", 32'(q1.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
